key_grid_placer: RTL and testbench

Parametrised successor to the single-square key placer. Tracks the PS/2 key counter `kcount` and places one square per typed key on a COLS×ROWS character grid on the VGA frame. The block steps forward on increments and back on decrements, one grid cell per clock. It outputs the registered bounding box (`xi`, `xf`, `yi`, `yf`) of the current cell to the VGA drawing logic in the 25 MHz domain.

---
 rtl/key_grid_placer_if.sv | 45 ++++
 rtl/key_grid_placer.sv | 190 +++++++++++++++++++
 tb/tb_key_grid_placer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/key_grid_placer_if.sv
// -----------------------------------------------------------------------------
// key_grid_placer_if
// Bundles the key-count input, the cursor clear and the cell/status outputs of
// key_grid_placer into one interface.
//   master modport : keyboard/test side; drives kcount and clr, observes results
//   slave  modport : the placer; consumes kcount and clr, drives results
// Signals:
//   kcount [7:0]      running key count (modulo 256)
//   clr               synchronous clear of the grid cursor
//   xi/xf/yi/yf [CW]  bounding box of the current cell
//   col/row           current grid position
//   busy              pending key steps (combinational)
//   step              one-cycle pulse per forward placement
//   full              cursor saturated at the last cell (non-wrapping mode)
// -----------------------------------------------------------------------------
interface key_grid_placer_if #(
  parameter int CW   = 10,
  parameter int COLS = 32,
  parameter int ROWS = 24
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [7:0]       kcount;
  logic             clr;
  logic [CW-1:0]    xi;
  logic [CW-1:0]    xf;
  logic [CW-1:0]    yi;
  logic [CW-1:0]    yf;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             busy;
  logic             step;
  logic             full;

  modport master (
    output kcount, clr,
    input  xi, xf, yi, yf, col, row, busy, step, full
  );

  modport slave (
    input  kcount, clr,
    output xi, xf, yi, yf, col, row, busy, step, full
  );
endinterface

// File: rtl/key_grid_placer.sv
// -----------------------------------------------------------------------------
// key_grid_placer
// Follows the PS/2 key counter and moves a square cursor over a COLS x ROWS
// character grid, one cell per clock: forward on increments, backward on
// decrements. The bounding box of the current cell is kept in registers and
// updated incrementally (add/subtract the pitch or reload an edge value), so
// no multiplier is needed.
// Ports:
//   clk25  pixel clock, the only clock
//   rst    synchronous active-high reset (resyncs to kcount, cursor to (0,0))
//   bus    key_grid_placer_if.slave:
//            in : kcount, clr
//            out: xi, xf, yi, yf, col, row, busy, step, full
// -----------------------------------------------------------------------------
module key_grid_placer #(
  parameter int CW   = 10,
  parameter int X0   = 0,
  parameter int Y0   = 0,
  parameter int SQ_W = 16,
  parameter int SQ_H = 16,
  parameter int GAP  = 4,
  parameter int COLS = 32,
  parameter int ROWS = 24,
  parameter int WRAP = 0
) (
  input  logic                clk25,
  input  logic                rst,
  key_grid_placer_if.slave    bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  // Far edges of the grid, used for the range check below.
  localparam longint X_END = longint'(X0) + longint'(COLS - 1) * longint'(SQ_W + GAP)
                             + longint'(SQ_W) - 64'sd1;
  localparam longint Y_END = longint'(Y0) + longint'(ROWS - 1) * longint'(SQ_H + GAP)
                             + longint'(SQ_H) - 64'sd1;
  localparam longint CW_LIMIT = 64'sd1 <<< CW;

  // Grid must fit inside the coordinate range.
  if (X_END >= CW_LIMIT) begin : g_x_range_bad
    $fatal(1, "key_grid_placer: x extent does not fit in CW bits");
  end
  if (Y_END >= CW_LIMIT) begin : g_y_range_bad
    $fatal(1, "key_grid_placer: y extent does not fit in CW bits");
  end
  if ((COLS < 2) || (ROWS < 2)) begin : g_grid_bad
    $fatal(1, "key_grid_placer: COLS and ROWS must be at least 2");
  end

  localparam logic [CW-1:0]    X0_C       = CW'(X0);
  localparam logic [CW-1:0]    Y0_C       = CW'(Y0);
  localparam logic [CW-1:0]    SQW_M1_C   = CW'(SQ_W - 1);
  localparam logic [CW-1:0]    SQH_M1_C   = CW'(SQ_H - 1);
  localparam logic [CW-1:0]    PITCH_X_C  = CW'(SQ_W + GAP);
  localparam logic [CW-1:0]    PITCH_Y_C  = CW'(SQ_H + GAP);
  // Left edge of the last column, reloaded when backing over a row boundary.
  localparam logic [CW-1:0]    XLAST_C    = CW'(X0 + (COLS - 1) * (SQ_W + GAP));
  localparam logic [COL_W-1:0] COLS_M1_C  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROWS_M1_C  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ZERO_C = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO_C = {ROW_W{1'b0}};

  logic [7:0]       kprev_q, kprev_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CW-1:0]    xi_q, xi_d;
  logic [CW-1:0]    xf_q, xf_d;
  logic [CW-1:0]    yi_q, yi_d;
  logic [CW-1:0]    yf_q, yf_d;
  logic             full_q, full_d;
  logic             step_q, step_d;

  logic [7:0]       delta_s;
  logic             fwd_s;
  logic             bwd_s;

  // Modulo-256 distance to the keyboard count; the top bit selects direction.
  assign delta_s = bus.kcount - kprev_q;
  assign fwd_s   = (delta_s != 8'd0) && !delta_s[7];
  assign bwd_s   = delta_s[7];

  // Next-state logic: clr > forward step > backward step > hold.
  always_comb begin
    kprev_d = kprev_q;
    col_d   = col_q;
    row_d   = row_q;
    xi_d    = xi_q;
    xf_d    = xf_q;
    yi_d    = yi_q;
    yf_d    = yf_q;
    full_d  = full_q;
    step_d  = 1'b0;

    if (bus.clr) begin
      kprev_d = bus.kcount;
      col_d   = COL_ZERO_C;
      row_d   = ROW_ZERO_C;
      xi_d    = X0_C;
      xf_d    = X0_C + SQW_M1_C;
      yi_d    = Y0_C;
      yf_d    = Y0_C + SQH_M1_C;
      full_d  = 1'b0;
    end else if (fwd_s) begin
      kprev_d = kprev_q + 8'd1;
      step_d  = 1'b1;
      if (col_q < COLS_M1_C) begin
        col_d = col_q + COL_W'(1);
        xi_d  = xi_q + PITCH_X_C;
        xf_d  = xf_q + PITCH_X_C;
      end else if (row_q < ROWS_M1_C) begin
        col_d = COL_ZERO_C;
        xi_d  = X0_C;
        xf_d  = X0_C + SQW_M1_C;
        row_d = row_q + ROW_W'(1);
        yi_d  = yi_q + PITCH_Y_C;
        yf_d  = yf_q + PITCH_Y_C;
      end else if (WRAP != 0) begin
        col_d = COL_ZERO_C;
        row_d = ROW_ZERO_C;
        xi_d  = X0_C;
        xf_d  = X0_C + SQW_M1_C;
        yi_d  = Y0_C;
        yf_d  = Y0_C + SQH_M1_C;
      end else begin
        // Saturate: the position stays on the last cell, only the flag moves.
        full_d = 1'b1;
      end
    end else if (bwd_s) begin
      kprev_d = kprev_q - 8'd1;
      if (full_q) begin
        // The first backspace after saturation only consumes the overflow key.
        full_d = 1'b0;
      end else if (col_q > COL_ZERO_C) begin
        col_d = col_q - COL_W'(1);
        xi_d  = xi_q - PITCH_X_C;
        xf_d  = xf_q - PITCH_X_C;
      end else if (row_q > ROW_ZERO_C) begin
        col_d = COLS_M1_C;
        xi_d  = XLAST_C;
        xf_d  = XLAST_C + SQW_M1_C;
        row_d = row_q - ROW_W'(1);
        yi_d  = yi_q - PITCH_Y_C;
        yf_d  = yf_q - PITCH_Y_C;
      end else begin
        col_d = col_q;
      end
    end else begin
      kprev_d = kprev_q;
    end
  end

  // State register with synchronous reset that resyncs to the current count.
  always_ff @(posedge clk25) begin
    if (rst) begin
      kprev_q <= bus.kcount;
      col_q   <= COL_ZERO_C;
      row_q   <= ROW_ZERO_C;
      xi_q    <= X0_C;
      xf_q    <= X0_C + SQW_M1_C;
      yi_q    <= Y0_C;
      yf_q    <= Y0_C + SQH_M1_C;
      full_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      kprev_q <= kprev_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xi_q    <= xi_d;
      xf_q    <= xf_d;
      yi_q    <= yi_d;
      yf_q    <= yf_d;
      full_q  <= full_d;
      step_q  <= step_d;
    end
  end

  assign bus.xi   = xi_q;
  assign bus.xf   = xf_q;
  assign bus.yi   = yi_q;
  assign bus.yf   = yf_q;
  assign bus.col  = col_q;
  assign bus.row  = row_q;
  assign bus.full = full_q;
  assign bus.step = step_q;
  // Pending work is visible immediately, before the next edge acts on it.
  assign bus.busy = (kprev_q != bus.kcount);

endmodule

// File: tb/tb_key_grid_placer.sv
// -----------------------------------------------------------------------------
// tb_key_grid_placer
// Directed bench for key_grid_placer with default geometry (32x24 grid, 16x16
// squares, 4 px gap, pitch 20). Instance A saturates (WRAP=0), instance B wraps
// (WRAP=1). Inputs change 1 time unit after a rising edge; outputs are checked
// at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_key_grid_placer;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  always #20 clk25 = ~clk25;

  key_grid_placer_if #(.CW(10), .COLS(32), .ROWS(24)) ifa ();
  key_grid_placer_if #(.CW(10), .COLS(32), .ROWS(24)) ifb ();

  key_grid_placer #(.WRAP(0)) dut_a (.clk25(clk25), .rst(rst), .bus(ifa));
  key_grid_placer #(.WRAP(1)) dut_b (.clk25(clk25), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  initial begin
    ifa.kcount = 8'd5; ifa.clr = 1'b0;
    ifb.kcount = 8'd5; ifb.clr = 1'b0;

    // Reset with kcount=5: no pending steps afterwards.
    tick(); tick();
    chk("rst_xi", ifa.xi, 0);
    chk("rst_xf", ifa.xf, 15);
    chk("rst_busy", ifa.busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_step", ifa.step, 0);
      chk("post_rst_busy", ifa.busy, 0);
    end
    chk("post_rst_xi", ifa.xi, 0);
    chk("post_rst_xf", ifa.xf, 15);
    chk("post_rst_yi", ifa.yi, 0);
    chk("post_rst_yf", ifa.yf, 15);
    chk("post_rst_full", ifa.full, 0);

    // Single key 0 -> 1.
    ifa.kcount = 8'd0; ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
    chk("clr_xi", ifa.xi, 0);
    chk("clr_busy", ifa.busy, 0);
    ifa.kcount = 8'd1;
    #1;
    chk("single_busy_pre", ifa.busy, 1);
    tick();
    chk("single_xi", ifa.xi, 20);
    chk("single_xf", ifa.xf, 35);
    chk("single_yi", ifa.yi, 0);
    chk("single_yf", ifa.yf, 15);
    chk("single_step", ifa.step, 1);
    chk("single_busy_post", ifa.busy, 0);
    tick();
    chk("single_step_end", ifa.step, 0);
    chk("single_xi_hold", ifa.xi, 20);

    // Burst 0 -> 3.
    ifa.kcount = 8'd0; ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
    ifa.kcount = 8'd3;
    tick();
    chk("burst1_xi", ifa.xi, 20);
    chk("burst1_step", ifa.step, 1);
    chk("burst1_busy", ifa.busy, 1);
    tick();
    chk("burst2_xi", ifa.xi, 40);
    chk("burst2_step", ifa.step, 1);
    chk("burst2_busy", ifa.busy, 1);
    tick();
    chk("burst3_xi", ifa.xi, 60);
    chk("burst3_step", ifa.step, 1);
    chk("burst3_busy", ifa.busy, 0);
    tick();
    chk("burst_step_end", ifa.step, 0);
    chk("burst_col", ifa.col, 3);

    // Burst abandoned by clr on its second cycle.
    ifa.kcount = 8'd0; ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
    ifa.kcount = 8'd3;
    tick();
    chk("abort1_xi", ifa.xi, 20);
    ifa.clr = 1'b1;
    tick();
    ifa.clr = 1'b0;
    chk("abort_xi", ifa.xi, 0);
    chk("abort_col", ifa.col, 0);
    chk("abort_row", ifa.row, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_step", ifa.step, 0);
    tick();
    chk("abort_xi_hold", ifa.xi, 0);

    // Row wrap: 31 keys to column 31, then one more.
    ifa.kcount = 8'd34;
    repeat (31) tick();
    chk("c31_col", ifa.col, 31);
    chk("c31_xi", ifa.xi, 620);
    chk("c31_busy", ifa.busy, 0);
    ifa.kcount = 8'd35;
    tick();
    chk("rowwrap_col", ifa.col, 0);
    chk("rowwrap_row", ifa.row, 1);
    chk("rowwrap_xi", ifa.xi, 0);
    chk("rowwrap_yi", ifa.yi, 20);
    chk("rowwrap_yf", ifa.yf, 35);
    ifa.kcount = 8'd34;
    tick();
    chk("bksp_col", ifa.col, 31);
    chk("bksp_row", ifa.row, 0);
    chk("bksp_xi", ifa.xi, 620);
    chk("bksp_xf", ifa.xf, 635);
    chk("bksp_yi", ifa.yi, 0);
    chk("bksp_step", ifa.step, 0);

    // Advance A from cell 31 to the last cell (767), one key per edge.
    for (int i = 0; i < 736; i++) begin
      ifa.kcount = ifa.kcount + 8'd1;
      tick();
    end
    chk("last_col", ifa.col, 31);
    chk("last_row", ifa.row, 23);
    chk("last_xi", ifa.xi, 620);
    chk("last_yi", ifa.yi, 460);
    chk("last_yf", ifa.yf, 475);
    chk("last_full", ifa.full, 0);
    ifa.kcount = ifa.kcount + 8'd1;
    tick();
    chk("sat_xi", ifa.xi, 620);
    chk("sat_yi", ifa.yi, 460);
    chk("sat_full", ifa.full, 1);
    chk("sat_step", ifa.step, 1);
    ifa.kcount = ifa.kcount - 8'd1;
    tick();
    chk("unsat_full", ifa.full, 0);
    chk("unsat_col", ifa.col, 31);
    chk("unsat_row", ifa.row, 23);
    chk("unsat_step", ifa.step, 0);
    ifa.kcount = ifa.kcount - 8'd1;
    tick();
    chk("back30_col", ifa.col, 30);
    chk("back30_row", ifa.row, 23);
    chk("back30_xi", ifa.xi, 600);

    // B (WRAP=1): 767 keys to the last cell, then wrap to (0,0).
    for (int i = 0; i < 767; i++) begin
      ifb.kcount = ifb.kcount + 8'd1;
      tick();
    end
    chk("b_last_col", ifb.col, 31);
    chk("b_last_row", ifb.row, 23);
    chk("b_last_yi", ifb.yi, 460);
    ifb.kcount = ifb.kcount + 8'd1;
    tick();
    chk("b_wrap_col", ifb.col, 0);
    chk("b_wrap_row", ifb.row, 0);
    chk("b_wrap_xi", ifb.xi, 0);
    chk("b_wrap_yi", ifb.yi, 0);
    chk("b_wrap_full", ifb.full, 0);
    chk("b_wrap_step", ifb.step, 1);

    // Counter rollover in both directions.
    ifb.kcount = 8'd255; ifb.clr = 1'b1;
    tick();
    ifb.clr = 1'b0;
    chk("b_clr_busy", ifb.busy, 0);
    ifb.kcount = 8'd0;
    tick();
    chk("roll_fwd_col", ifb.col, 1);
    chk("roll_fwd_step", ifb.step, 1);
    chk("roll_fwd_busy", ifb.busy, 0);
    tick();
    chk("roll_fwd_once", ifb.col, 1);
    ifb.kcount = 8'd255;
    tick();
    chk("roll_bwd_col", ifb.col, 0);
    chk("roll_bwd_step", ifb.step, 0);
    chk("roll_bwd_busy", ifb.busy, 0);
    ifb.kcount = 8'd254;
    tick();
    chk("origin_hold_col", ifb.col, 0);
    chk("origin_hold_row", ifb.row, 0);
    chk("origin_hold_xi", ifb.xi, 0);
    chk("origin_hold_busy", ifb.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
